// File: rtl/instr_encode_loader_pkg.sv
// rtl/instr_encode_loader_pkg.sv - shared formats, field positions and FSM state for the RV32I encoder/loader
package instr_encode_loader_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic fmt_legal(input logic [2:0] f);
    return f <= FMT_J;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational RV32I field bundle to 32-bit instruction word
module instr_field_packer
  import instr_encode_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  assign illegal = !fmt_legal(fmt);

  always_comb begin
    word = '0;
    word[OPCODE_LSB +: 7] = opcode;
    case (fmt)
      FMT_R: begin
        word[RD_LSB +: 5]     = rd;
        word[FUNCT3_LSB +: 3] = funct3;
        word[RS1_LSB +: 5]    = rs1;
        word[RS2_LSB +: 5]    = rs2;
        word[FUNCT7_LSB +: 7] = funct7;
      end
      FMT_I: begin
        word[RD_LSB +: 5]     = rd;
        word[FUNCT3_LSB +: 3] = funct3;
        word[RS1_LSB +: 5]    = rs1;
        word[31:20]           = imm[11:0];
      end
      FMT_S: begin
        word[FUNCT3_LSB +: 3] = funct3;
        word[RS1_LSB +: 5]    = rs1;
        word[RS2_LSB +: 5]    = rs2;
        word[31:25]           = imm[11:5];
        word[11:7]            = imm[4:0];
      end
      FMT_B: begin
        word[FUNCT3_LSB +: 3] = funct3;
        word[RS1_LSB +: 5]    = rs1;
        word[RS2_LSB +: 5]    = rs2;
        word[31]              = imm[12];
        word[30:25]           = imm[10:5];
        word[11:8]            = imm[4:1];
        word[7]               = imm[11];
      end
      FMT_U: begin
        word[RD_LSB +: 5] = rd;
        word[31:12]       = imm[31:12];
      end
      FMT_J: begin
        word[RD_LSB +: 5] = rd;
        word[31]          = imm[20];
        word[30:21]       = imm[10:1];
        word[20]          = imm[11];
        word[19:12]       = imm[19:12];
      end
      default: word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - accepts field bundles, encodes them and writes words sequentially to instruction RAM
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              fmt_err,
  output logic              ovf_err
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t state, state_nxt;

  logic [31:0]       packed_word;
  logic              packed_illegal;
  logic [31:0]       wdata_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fmt_err_q;
  logic              ovf_err_q;
  logic              accept;
  logic              at_max;

  instr_field_packer u_packer (
    .fmt     (fmt),
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .imm     (imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  assign accept = (state == ST_ACCEPT) && in_valid;
  assign at_max = (addr_q == ADDR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACCEPT;
      ST_ACCEPT: if (in_valid) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (last_q || at_max) ? ST_DONE : ST_ACCEPT;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE:   busy     = 1'b0;
      ST_ACCEPT: in_ready = 1'b1;
      ST_WRITE:  mem_we   = 1'b1;
      ST_DONE:   done     = 1'b1;
      default:   busy     = 1'b0;
    endcase
  end

  // The word is encoded at acceptance so the source may change fields while the write is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q   <= '0;
      last_q    <= 1'b0;
      addr_q    <= BASE;
      fmt_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr_q    <= BASE;
        fmt_err_q <= 1'b0;
        ovf_err_q <= 1'b0;
      end
      if (accept) begin
        wdata_q <= packed_word;
        last_q  <= in_last;
        if (packed_illegal) fmt_err_q <= 1'b1;
      end
      // The top word is still written; the address saturates rather than wrapping.
      if (state == ST_WRITE) begin
        if (!at_max) begin
          addr_q <= addr_q + ADDR_W'(1);
        end else if (!last_q) begin
          ovf_err_q <= 1'b1;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign fmt_err   = fmt_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - self-checking bench for instr_encode_loader
module tb_instr_encode_loader;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [2:0] fmt = '0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm = '0;

  logic in_ready, mem_we, busy, done, fmt_err, ovf_err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic s_in_ready, s_mem_we, s_busy, s_done, s_fmt_err, s_ovf_err;
  logic [1:0] s_mem_addr;
  logic [31:0] s_mem_wdata;

  logic sel_small = 1'b0;
  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int we_base;

  instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .fmt_err(fmt_err), .ovf_err(ovf_err)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done), .fmt_err(s_fmt_err), .ovf_err(s_ovf_err)
  );

  always #5 clk = ~clk;

  wire        c_ready = sel_small ? s_in_ready : in_ready;
  wire        c_we    = sel_small ? s_mem_we : mem_we;
  wire [31:0] c_addr  = sel_small ? 32'(s_mem_addr) : 32'(mem_addr);
  wire [31:0] c_wdata = sel_small ? s_mem_wdata : mem_wdata;
  wire        c_done  = sel_small ? s_done : done;
  wire        c_busy  = sel_small ? s_busy : busy;
  wire        c_ovf   = sel_small ? s_ovf_err : ovf_err;

  always @(negedge clk) if (c_we) we_count++;

  // Reference encoding built from the ISA field layout with shifts and masks.
  function automatic logic [31:0] encode(input bundle_t b);
    logic [31:0] common;
    common = 32'(b.funct3) << 12 | 32'(b.rs1) << 15 | 32'(b.opcode);
    case (b.fmt)
      3'd0: return 32'(b.funct7) << 25 | 32'(b.rs2) << 20 | common | 32'(b.rd) << 7;
      3'd1: return (b.imm & 32'hfff) << 20 | common | 32'(b.rd) << 7;
      3'd2: return ((b.imm >> 5) & 32'h7f) << 25 | 32'(b.rs2) << 20 | common | (b.imm & 32'h1f) << 7;
      3'd3: return ((b.imm >> 12) & 32'h1) << 31 | ((b.imm >> 5) & 32'h3f) << 25 | 32'(b.rs2) << 20
                   | common | ((b.imm >> 1) & 32'hf) << 8 | ((b.imm >> 11) & 32'h1) << 7;
      3'd4: return (b.imm & 32'hffff_f000) | 32'(b.rd) << 7 | 32'(b.opcode);
      3'd5: return ((b.imm >> 20) & 32'h1) << 31 | ((b.imm >> 1) & 32'h3ff) << 21
                   | ((b.imm >> 11) & 32'h1) << 20 | ((b.imm >> 12) & 32'hff) << 12
                   | 32'(b.rd) << 7 | 32'(b.opcode);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] d, input logic [31:0] im);
    bundle_t b;
    b.fmt = f; b.opcode = op; b.funct3 = f3; b.funct7 = f7;
    b.rs1 = s1; b.rs2 = s2; b.rd = d; b.imm = im;
    return b;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b = bundle_t'({$urandom, $urandom, $urandom});
    b.fmt = 3'($urandom_range(5, 0));
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    we_base = we_count;
  endtask

  task automatic send(input bundle_t b, input logic last, input logic [31:0] exp_word,
                      input int exp_addr, input int max_gap, input string tag);
    int n;
    @(negedge clk);
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    {fmt, opcode, funct3, funct7, rs1, rs2, rd, imm} = b;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!c_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {fmt, opcode, funct3, funct7, rs1, rs2, rd, imm} = bundle_t'({$urandom, $urandom, $urandom});
    in_last = 1'($urandom);
    check({tag, "_we"}, 32'(c_we), 32'd1);
    check({tag, "_addr"}, c_addr, 32'(exp_addr));
    check({tag, "_wdata"}, c_wdata, exp_word);
  endtask

  task automatic end_session(input logic exp_ovf, input int exp_writes, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(c_done), 32'd1);
    check({tag, "_ovf"}, 32'(c_ovf), 32'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(c_done), 32'd0);
    check({tag, "_idle"}, 32'(c_busy), 32'd0);
    check({tag, "_writes"}, 32'(we_count - we_base), 32'(exp_writes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t b;
    int addr;

    repeat (3) @(negedge clk);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_flags", {28'd0, busy, done, fmt_err, ovf_err}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    start_session();
    check("busy_accept", 32'(busy), 32'd1);
    send(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5), 1'b1, 32'h0050_0093, 0, 0, "addi");
    end_session(1'b0, 1, "addi");

    start_session();
    send(mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0), 1'b0, 32'h0020_81B3, 0, 2, "add");
    send(mk(3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8), 1'b0, 32'h0020_A423, 1, 2, "sw");
    send(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, -32'sd4), 1'b1, 32'hFE20_8EE3, 2, 2, "beq");
    end_session(1'b0, 3, "rsb");

    start_session();
    send(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000), 1'b0, 32'h1234_52B7, 0, 4, "lui");
    send(mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8), 1'b1, 32'h0080_00EF, 1, 4, "jal");
    end_session(1'b0, 2, "uj");

    start_session();
    send(mk(3'd7, 7'h33, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFFF), 1'b1, 32'h0000_0013, 0, 1, "illegal");
    check("fmt_err_set", 32'(fmt_err), 32'd1);
    end_session(1'b0, 1, "illegal");
    check("fmt_err_sticky", 32'(fmt_err), 32'd1);

    start_session();
    check("fmt_err_clear", 32'(fmt_err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      b = rnd_bundle();
      send(b, 1'(i == 19), encode(b), i, 3, $sformatf("rnd%0d", i));
    end
    end_session(1'b0, 20, "rnd");
    check("rnd_fmt_err", 32'(fmt_err), 32'd0);

    sel_small = 1'b1;
    start_session();
    addr = 0;
    for (int i = 0; i < 4; i++) begin
      b = rnd_bundle();
      send(b, 1'b0, encode(b), addr, 1, $sformatf("ovf%0d", i));
      addr++;
    end
    end_session(1'b1, 4, "ovf");
    @(negedge clk);
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ovf_5th_ready%0d", i), 32'(s_in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("ovf_5th_writes", 32'(we_count - we_base), 32'd4);
    check("ovf_sticky", 32'(s_ovf_err), 32'd1);
    sel_small = 1'b0;

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_session();
    b = rnd_bundle();
    send(b, 1'b0, encode(b), 0, 0, "pre_abort");
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_session();
    send(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5), 1'b1, 32'h0050_0093, 0, 0, "resume");
    end_session(1'b0, 1, "resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
